synaptic_accumulator: RTL
=========================

# synaptic_accumulator

Downstream of `synapse_array`: takes its weighted spike stream (neuron id, 8-bit magnitude, excitatory/inhibitory flag) and integrates a signed, saturating synaptic current per neuron over one timestep. On each `timestep_tick`, it freezes the accumulated bank and drains the non-zero currents, in ascending neuron order, to the neuron array over a valid/ready handshake. Double buffering lets the next timestep accumulate while the previous one drains.

## Interface
Parameters:
- `NUM_NEURONS`, 8: number of post-synaptic neurons.
- `NEURON_ID_WIDTH`, 3: equals log2(`NUM_NEURONS`).
- `WEIGHT_WIDTH`, 8: unsigned weight magnitude width.
- `ACC_WIDTH`, 16: signed two's-complement accumulator width; must exceed `WEIGHT_WIDTH`+1.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: when low, `syn_valid` and `timestep_tick` are ignored.
- `syn_valid` input 1: one synaptic event per cycle; there is no backpressure.
- `syn_neuron_id` input `NEURON_ID_WIDTH`: target neuron.
- `syn_weight` input `WEIGHT_WIDTH`: weight magnitude.
- `syn_exc_inh` input 1: 1 adds the weight, 0 subtracts it.
- `timestep_tick` input 1: single-cycle pulse that ends the current timestep.
- `out_valid` output 1: drained current available.
- `out_neuron_id` output `NEURON_ID_WIDTH`: neuron index of the drained current.
- `out_current` output `ACC_WIDTH`: signed accumulated current.
- `out_ready` input 1: consumer accepts the output when high together with `out_valid`.
- `busy` output 1: drain in progress.
- `drain_done` output 1: one-cycle pulse after the last entry has been drained.
- `sat_flag` output 1: sticky; set when any accumulation saturated.
- `overrun_flag` output 1: sticky; set when a tick arrives while `busy` is high.

## Operation
- Two register banks, each holding `NUM_NEURONS` × `ACC_WIDTH` entries. `act` selects the accumulating bank; the other bank is frozen for draining.
- Accumulate: when `syn_valid && enable`, the entry `bank[act][id]` is updated with ±`syn_weight`, zero-extended, and written in the same cycle.
  - Back-to-back events to the same neuron each take effect; none is lost.
- Saturation: the result is clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp sets `sat_flag`.
- A zero-weight event leaves the entry unchanged.
- Tick accepted when `timestep_tick && enable && !busy`:
  - `act` toggles.
  - The FSM moves IDLE→SCAN with `idx`=0.
  - An event in the tick cycle lands in the newly active bank.
- Tick while `busy`: the tick is ignored, `act` is unchanged, `overrun_flag` is set, and the drain continues.
- FSM states:
  - IDLE: `busy`=0.
  - SCAN: examines frozen entry `idx`.
    - Non-zero entry → OUT.
    - Zero entry with `idx`<`NUM_NEURONS`-1 → increment `idx`.
    - Zero entry with `idx` = last → DONE.
  - OUT: `out_valid`=1, `out_neuron_id`=`idx`, `out_current`=entry. These outputs stay stable until `out_ready`. On handshake the entry is cleared to 0, then `idx`++ → SCAN, or DONE if `idx` was last.
  - DONE: `drain_done`=1 for one cycle, then IDLE.
- The drain clears every non-zero frozen entry, so the bank is all-zero when it next becomes active.
- `enable` low mid-drain: the drain still completes; only new events and ticks are blocked.

## Timing
- Reset (async assert): both banks are cleared, `act`=0, FSM goes to IDLE.
  - All outputs are 0: `out_valid`, `out_neuron_id`, `out_current`, `busy`, `drain_done`, `sat_flag`, `overrun_flag`.
  - A drain in progress is aborted with no `drain_done`.
- Accumulation latency is 1 cycle: an event sampled at edge N is visible in the entry after edge N.
- Tick sampled at edge T:
  - `busy`=1 from T.
  - SCAN of `idx` 0 occurs in cycle T+1.
  - If entry 0 is non-zero, `out_valid` rises after edge T+1.
- Drain cost:
  - Each zero entry costs 1 cycle.
  - Each non-zero entry costs 1 SCAN cycle plus at least 1 OUT cycle.
  - With `out_ready` tied high, a fully non-zero bank drains in 2·`NUM_NEURONS`+1 cycles including DONE.
- Outputs are registered state; `out_*` never changes while `out_valid && !out_ready`.
- `busy` deasserts in the cycle after DONE, coincident with IDLE.

## Test plan
- Accumulate then drain:
  - Stimulus: events (n0,+10), (n0,+20), (n3,−5), then a tick, with `out_ready`=1.
  - Required: exactly two outputs, (0,30) then (3,−5), then a `drain_done` pulse.
- Saturation:
  - Stimulus: 130 events of (n1,+255, exc) with `ACC_WIDTH`=16, then a tick.
  - Required: output (1,32767) and `sat_flag`=1. Repeat with inhibitory events → (1,−32768).
- Backpressure:
  - Stimulus: all 8 neurons non-zero; `out_ready` toggles 1-of-3 cycles.
  - Required: 8 outputs in order 0..7, and id/current stable during every stall.
- Double buffering:
  - Stimulus: events (n2,+7) during a drain and one coincident with the tick.
  - Required: these appear only in the next drain; the current drain is unaffected.
- Overrun:
  - Stimulus: a second tick while `busy`, with `out_ready`=0.
  - Required: `overrun_flag`=1, `act` unchanged, and the current drain finishes intact.
- Reset mid-drain:
  - Stimulus: assert `rst_n`=0 while in OUT.
  - Required: `out_valid`=0 and `busy`=0 immediately; a tick after release with no events produces zero outputs and only a `drain_done` pulse after `NUM_NEURONS`+1 cycles.

Source files
------------

// File: rtl/synaptic_accumulator.sv
// synaptic_accumulator
//   Integrates a signed, saturating synaptic current per neuron over one timestep.
//   It keeps two banks of accumulators. One bank accumulates. When a tick is
//   accepted, the banks swap roles and the frozen bank drains its non-zero entries
//   in ascending neuron order. Each drained entry is cleared as it is handed over.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   enable                            gates syn_valid and timestep_tick
//   syn_valid/_neuron_id/_weight/_exc_inh   one weighted spike per cycle, no backpressure
//   timestep_tick                     ends the current timestep
//   out_valid/_neuron_id/_current, out_ready   drain handshake
//   busy, drain_done                  drain status
//   sat_flag, overrun_flag            sticky error flags
module synaptic_accumulator #(
    parameter int unsigned NUM_NEURONS     = 8,
    parameter int unsigned NEURON_ID_WIDTH = 3,
    parameter int unsigned WEIGHT_WIDTH    = 8,
    parameter int unsigned ACC_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       syn_valid,
    input  logic [NEURON_ID_WIDTH-1:0] syn_neuron_id,
    input  logic [WEIGHT_WIDTH-1:0]    syn_weight,
    input  logic                       syn_exc_inh,
    input  logic                       timestep_tick,
    output logic                       out_valid,
    output logic [NEURON_ID_WIDTH-1:0] out_neuron_id,
    output logic [ACC_WIDTH-1:0]       out_current,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       drain_done,
    output logic                       sat_flag,
    output logic                       overrun_flag
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StOut  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [NEURON_ID_WIDTH-1:0] LastIdx = NEURON_ID_WIDTH'(NUM_NEURONS - 1);
    localparam logic [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH-1:0]       bank_q [2][NUM_NEURONS];
    logic [ACC_WIDTH-1:0]       bank_d [2][NUM_NEURONS];
    logic                       act_q, act_d;
    logic [1:0]                 state_q, state_d;
    logic [NEURON_ID_WIDTH-1:0] idx_q, idx_d;
    logic [ACC_WIDTH-1:0]       cur_q, cur_d;
    logic                       sat_q, sat_d;
    logic                       ovr_q, ovr_d;

    logic                 tick_acc;
    logic                 wr_bank;
    logic                 frz_bank;
    logic [ACC_WIDTH-1:0] wr_old;
    logic [ACC_WIDTH-1:0] frz_entry;
    logic [ACC_WIDTH:0]   w_ext;
    logic [ACC_WIDTH:0]   sum;

    assign tick_acc = timestep_tick & enable & (state_q == StIdle);
    // An event coinciding with an accepted tick belongs to the next timestep.
    assign wr_bank   = act_q ^ tick_acc;
    assign frz_bank  = ~act_q;
    assign wr_old    = bank_q[wr_bank][syn_neuron_id];
    assign frz_entry = bank_q[frz_bank][idx_q];
    assign w_ext     = {{(ACC_WIDTH + 1 - WEIGHT_WIDTH){1'b0}}, syn_weight};
    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign sum = syn_exc_inh ? ({wr_old[ACC_WIDTH-1], wr_old} + w_ext)
                             : ({wr_old[ACC_WIDTH-1], wr_old} - w_ext);

    always_comb begin
        bank_d  = bank_q;
        act_d   = act_q;
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        sat_d   = sat_q;
        ovr_d   = ovr_q;

        if (syn_valid && enable) begin
            if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                bank_d[wr_bank][syn_neuron_id] = sum[ACC_WIDTH] ? AccMin : AccMax;
                sat_d = 1'b1;
            end else begin
                bank_d[wr_bank][syn_neuron_id] = sum[ACC_WIDTH-1:0];
            end
        end

        if (timestep_tick && enable && (state_q != StIdle)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (tick_acc) begin
                    act_d   = ~act_q;
                    state_d = StScan;
                    idx_d   = '0;
                end
            end
            StScan: begin
                if (frz_entry != '0) begin
                    state_d = StOut;
                    cur_d   = frz_entry;
                end else if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StOut: begin
                if (out_ready) begin
                    // The frozen bank never takes events, so clearing here cannot collide.
                    bank_d[frz_bank][idx_q] = '0;
                    cur_d = '0;
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StScan;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int n = 0; n < int'(NUM_NEURONS); n++) begin
                    bank_q[b][n] <= '0;
                end
            end
            act_q   <= 1'b0;
            state_q <= StIdle;
            idx_q   <= '0;
            cur_q   <= '0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            bank_q  <= bank_d;
            act_q   <= act_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_valid     = (state_q == StOut);
    assign out_neuron_id = idx_q;
    assign out_current   = cur_q;
    assign busy          = (state_q != StIdle);
    assign drain_done    = (state_q == StDone);
    assign sat_flag      = sat_q;
    assign overrun_flag  = ovr_q;

endmodule
